fifo_stream_reader: RTL and testbench

Read-side drain engine for the team's FIFO shift register. It issues read pulses to the FIFO and absorbs the FIFO's one-cycle registered read latency. It re-presents the words in order on a valid/ready output stream with full throughput and backpressure. It sits between the FIFO's read port (dataOut/empty/readEnable) and any downstream consumer.

---
 rtl/fifo_stream_reader.sv | 84 ++++++++
 tb/tb_fifo_stream_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads, absorbs the one-cycle read
// latency and re-presents the words on a valid/ready stream.
module fifo_stream_reader #(
  parameter int unsigned FIFO_width  = 32,
  parameter int unsigned COUNT_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   fifoReadEnable,
  input  logic [FIFO_width-1:0]  fifoDataOut,
  input  logic                   fifoEmpty,
  output logic [FIFO_width-1:0]  outData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [COUNT_width-1:0] wordsRead,
  output logic                   busy
);

  localparam int unsigned OCC_W = 2;

  logic [OCC_W-1:0]       occ_q;
  logic                   in_flight_q;
  logic [FIFO_width-1:0]  buf0_q;
  logic [FIFO_width-1:0]  buf1_q;
  logic [COUNT_width-1:0] words_q;

  logic                   pop_c;
  logic [OCC_W-1:0]       fill_c;

  // Stream handshake and read issue; a pop frees a slot in the same cycle
  always_comb begin
    pop_c          = (occ_q != OCC_W'(0)) && outReady;
    fill_c         = occ_q + OCC_W'(in_flight_q);
    fifoReadEnable = reset && enable && !fifoEmpty &&
                     ((fill_c < OCC_W'(2)) || pop_c);
  end

  assign outValid  = (occ_q != OCC_W'(0));
  assign outData   = buf0_q;
  assign wordsRead = words_q;
  assign busy      = (occ_q != OCC_W'(0)) || in_flight_q;

  // Skid buffer, in-flight tracking and pop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q       <= '0;
      in_flight_q <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      words_q     <= '0;
    end else begin
      in_flight_q <= fifoReadEnable;
      if (pop_c) begin
        words_q <= words_q + COUNT_width'(1);
      end
      case ({in_flight_q, pop_c})
        2'b10: begin
          if (occ_q == OCC_W'(0)) begin
            buf0_q <= fifoDataOut;
          end else begin
            buf1_q <= fifoDataOut;
          end
          occ_q <= occ_q + OCC_W'(1);
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - OCC_W'(1);
        end
        2'b11: begin
          // Occupancy unchanged: new word lands behind the surviving one
          if (occ_q == OCC_W'(1)) begin
            buf0_q <= fifoDataOut;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= fifoDataOut;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO read port.
module tb_fifo_stream_reader;

  localparam int unsigned FW = 32;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifoReadEnable;
  logic [FW-1:0] fifoDataOut = '0;
  logic          fifoEmpty;
  logic [FW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic [CW-1:0] wordsRead;
  logic          busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [FW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int base;
  int pops;

  fifo_stream_reader #(.FIFO_width(FW), .COUNT_width(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifoReadEnable(fifoReadEnable), .fifoDataOut(fifoDataOut),
    .fifoEmpty(fifoEmpty), .outData(outData), .outValid(outValid),
    .outReady(outReady), .wordsRead(wordsRead), .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifoEmpty = (rd_ptr == wr_ptr);

  // FIFO read port: dataOut registered at the edge that accepts a read
  always @(posedge clk) begin
    if (fifoReadEnable && !fifoEmpty) begin
      fifoDataOut <= mem[rd_ptr[5:0]];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [FW-1:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; outReady = 1'b1;
    push(32'hA); push(32'hB); push(32'hC);

    // Reset held with a non-empty FIFO
    nxt; #1;
    chk("rst_rden", 32'(fifoReadEnable), 32'd0);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_data", outData, 32'd0);
    chk("rst_count", 32'(wordsRead), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nxt; #1;
    chk("rst_rden2", 32'(fifoReadEnable), 32'd0);
    chk("rst_noread", 32'(rd_ptr), 32'd0);

    // Streaming A, B, C
    nxt; reset = 1'b1; #1;
    chk("st_rden0", 32'(fifoReadEnable), 32'd1);
    chk("st_valid0", 32'(outValid), 32'd0);
    nxt; #1;
    chk("st_rden1", 32'(fifoReadEnable), 32'd1);
    chk("st_valid1", 32'(outValid), 32'd0);
    nxt; #1;
    chk("st_rden2", 32'(fifoReadEnable), 32'd1);
    chk("st_valid2", 32'(outValid), 32'd1);
    chk("st_dataA", outData, 32'hA);
    nxt; #1;
    chk("st_rden3", 32'(fifoReadEnable), 32'd0);
    chk("st_dataB", outData, 32'hB);
    chk("st_cnt1", 32'(wordsRead), 32'd1);
    nxt; #1;
    chk("st_dataC", outData, 32'hC);
    chk("st_cnt2", 32'(wordsRead), 32'd2);
    chk("st_busy", 32'(busy), 32'd1);
    nxt; #1;
    chk("st_valid_end", 32'(outValid), 32'd0);
    chk("st_cnt3", 32'(wordsRead), 32'd3);
    chk("st_busy_end", 32'(busy), 32'd0);
    chk("st_empty_rden", 32'(fifoReadEnable), 32'd0);

    // Backpressure with five words queued
    nxt; reset = 1'b0; #1;
    nxt; reset = 1'b1; outReady = 1'b0;
    base = rd_ptr;
    for (int i = 0; i < 5; i++) push(32'hD0 + 32'(i));
    #1;
    chk("bp_rden0", 32'(fifoReadEnable), 32'd1);
    nxt; #1;
    chk("bp_rden1", 32'(fifoReadEnable), 32'd1);
    nxt; #1;
    chk("bp_rden2", 32'(fifoReadEnable), 32'd0);
    chk("bp_data0", outData, 32'hD0);
    nxt; #1;
    chk("bp_rden3", 32'(fifoReadEnable), 32'd0);
    chk("bp_hold", outData, 32'hD0);
    nxt; #1;
    chk("bp_hold2", outData, 32'hD0);
    chk("bp_valid", 32'(outValid), 32'd1);
    chk("bp_reads", 32'(rd_ptr - base), 32'd2);
    nxt; outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid_i", 32'(outValid), 32'd1);
      chk("bp_data_i", outData, 32'hD0 + 32'(i));
      nxt;
    end
    #1;
    chk("bp_valid_end", 32'(outValid), 32'd0);
    chk("bp_cnt", 32'(wordsRead), 32'd5);
    chk("bp_reads_all", 32'(rd_ptr - base), 32'd5);

    // Enable dropped right after a read is accepted
    nxt; push(32'hE0); push(32'hE1); #1;
    chk("en_rden0", 32'(fifoReadEnable), 32'd1);
    nxt; enable = 1'b0; #1;
    chk("en_rden_off", 32'(fifoReadEnable), 32'd0);
    chk("en_busy", 32'(busy), 32'd1);
    nxt; #1;
    chk("en_valid", 32'(outValid), 32'd1);
    chk("en_data", outData, 32'hE0);
    chk("en_rden_off2", 32'(fifoReadEnable), 32'd0);
    nxt; #1;
    chk("en_valid_end", 32'(outValid), 32'd0);
    chk("en_cnt", 32'(wordsRead), 32'd6);
    nxt; #1;
    chk("en_rden_off3", 32'(fifoReadEnable), 32'd0);
    nxt; enable = 1'b1; #1;
    chk("en_resume", 32'(fifoReadEnable), 32'd1);
    nxt; #1;
    chk("en_rden_empty", 32'(fifoReadEnable), 32'd0);
    nxt; #1;
    chk("en_data1", outData, 32'hE1);
    nxt; #1;
    chk("en_cnt2", 32'(wordsRead), 32'd7);
    chk("en_busy_end", 32'(busy), 32'd0);

    // Reset with one word buffered and one in flight
    nxt; outReady = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hF0 + 32'(i));
    #1;
    chk("rm_rden0", 32'(fifoReadEnable), 32'd1);
    nxt; #1;
    chk("rm_rden1", 32'(fifoReadEnable), 32'd1);
    nxt; #1;
    chk("rm_pre_valid", 32'(outValid), 32'd1);
    chk("rm_pre_data", outData, 32'hF0);
    reset = 1'b0; #1;
    chk("rm_valid", 32'(outValid), 32'd0);
    chk("rm_data", outData, 32'd0);
    chk("rm_cnt", 32'(wordsRead), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_rden", 32'(fifoReadEnable), 32'd0);
    nxt; #1;
    chk("rm_rden_hold", 32'(fifoReadEnable), 32'd0);
    nxt; reset = 1'b1; outReady = 1'b1; #1;
    chk("rm_rden_rel", 32'(fifoReadEnable), 32'd1);
    nxt; #1;
    chk("rm_valid_lat", 32'(outValid), 32'd0);
    nxt; #1;
    chk("rm_next_data", outData, 32'hF2);
    nxt; #1;
    chk("rm_next_data2", outData, 32'hF3);
    nxt; #1;
    chk("rm_valid_end", 32'(outValid), 32'd0);
    chk("rm_cnt2", 32'(wordsRead), 32'd2);

    // Counter wrap over nine pops with a 3-bit counter
    nxt; reset = 1'b0; #1;
    nxt; reset = 1'b1;
    for (int i = 0; i < 9; i++) push(32'h100 + 32'(i));
    pops = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      chk("wr_cnt", 32'(wordsRead), 32'(pops % 8));
      if (outValid) begin
        if (pops < 9) chk("wr_data", outData, 32'h100 + 32'(pops));
        else chk("wr_extra_pop", 32'(pops), 32'd8);
        pops++;
      end
      nxt;
    end
    #1;
    chk("wr_pops", 32'(pops), 32'd9);
    chk("wr_final", 32'(wordsRead), 32'd1);
    chk("wr_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
